// File: rtl/register_bank_pkg.sv
// Shared constants and types for the 8-register general-purpose register bank.
package register_bank_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned NUM_REGS = 2 ** SEL_W;

    typedef logic [SEL_W-1:0]  reg_sel_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage : register_bank_pkg

// File: rtl/register_bank_if.sv
// Control, address and operand-read signals of the register bank.
// The tri-state bus output stays a plain port on the bank itself.
interface register_bank_if;
    import register_bank_pkg::*;

    logic      write_en;
    logic      read_en;
    reg_sel_t  in_rx_selector;
    reg_sel_t  in_ry_selector;
    logic      in_indirect_mode_en;
    reg_data_t in_data;
    reg_data_t out_rx_data;
    reg_data_t out_ry_data;

    // Datapath controller side.
    modport master (
        output write_en,
        output read_en,
        output in_rx_selector,
        output in_ry_selector,
        output in_indirect_mode_en,
        output in_data,
        input  out_rx_data,
        input  out_ry_data
    );

    // Register bank side.
    modport slave (
        input  write_en,
        input  read_en,
        input  in_rx_selector,
        input  in_ry_selector,
        input  in_indirect_mode_en,
        input  in_data,
        output out_rx_data,
        output out_ry_data
    );

endinterface : register_bank_if

// File: rtl/register_bank.sv
// General-purpose register bank: one synchronous write port (Rx), two
// combinational operand read ports (Rx, Ry) and one tri-state bus read
// port with optional indirect addressing R[R[ry][2:0]].
module register_bank #(
    parameter int unsigned DATA_W   = register_bank_pkg::DATA_W,
    parameter int unsigned NUM_REGS = register_bank_pkg::NUM_REGS,
    parameter int unsigned SEL_W    = register_bank_pkg::SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    register_bank_if.slave    rb,
    output logic [DATA_W-1:0] out_bus_data
);
    import register_bank_pkg::*;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic [DATA_W-1:0] ry_data;
    logic [SEL_W-1:0]  ind_sel;
    logic [DATA_W-1:0] ind_data;
    logic [DATA_W-1:0] bus_data;

    // Next-state: only the Rx-addressed register takes in_data on a write.
    always_comb begin
        regs_d = regs_q;
        if (rb.write_en) begin
            regs_d[rb.in_rx_selector] = rb.in_data;
        end
    end

    // Register array with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Operand read muxes; the indirect mux is cascaded on the Ry mux output,
    // using only the low selector bits of R[ry] as the pointer.
    always_comb begin
        ry_data  = regs_q[rb.in_ry_selector];
        ind_sel  = ry_data[SEL_W-1:0];
        ind_data = regs_q[ind_sel];
        bus_data = rb.in_indirect_mode_en ? ind_data : ry_data;
    end

    assign rb.out_rx_data = regs_q[rb.in_rx_selector];
    assign rb.out_ry_data = ry_data;

    // Bus is released whenever the bank is not selected for a bus read.
    assign out_bus_data = rb.read_en ? bus_data : 'z;

endmodule : register_bank

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: stimulus pushes expected values,
// a monitor pops and compares them against the sampled DUT outputs.
// The bus net carries a pull-up, so a released bus reads 8'hFF.
module tb_register_bank;
    import register_bank_pkg::*;

    localparam int KIND_RX  = 0;
    localparam int KIND_RY  = 1;
    localparam int KIND_BUS = 2;

    typedef struct {
        int        kind;
        logic [7:0] exp;
        string     name;
    } sb_item_t;

    logic clk;
    logic rst_n;
    tri1 [7:0] bus_w;

    register_bank_if rb_if ();

    register_bank #(
        .DATA_W   (8),
        .NUM_REGS (8),
        .SEL_W    (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rb           (rb_if.slave),
        .out_bus_data (bus_w)
    );

    sb_item_t sb_q[$];
    event     mon_ev;
    int       checks   = 0;
    int       failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: whenever stimulus signals that outputs are settled, pop one
    // expectation and compare it against the selected DUT output.
    initial begin
        sb_item_t   it;
        logic [7:0] act;
        forever begin
            @(mon_ev);
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                case (it.kind)
                    KIND_RX: act = rb_if.out_rx_data;
                    KIND_RY: act = rb_if.out_ry_data;
                    default: act = bus_w;
                endcase
                checks++;
                if (act !== it.exp) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic expect_out(input int kind, input logic [7:0] exp, input string name);
        sb_item_t it;
        it.kind = kind;
        it.exp  = exp;
        it.name = name;
        #1;
        sb_q.push_back(it);
        -> mon_ev;
        #1;
    endtask

    // Write one register: inputs set after a falling edge, one rising edge.
    task automatic do_write(input logic [2:0] sel, input logic [7:0] data);
        @(negedge clk);
        rb_if.write_en       = 1'b1;
        rb_if.in_rx_selector = sel;
        rb_if.in_data        = data;
        @(posedge clk);
        #1;
        rb_if.write_en = 1'b0;
    endtask

    initial begin
        int wait_cnt;
        rst_n                     = 1'b0;
        rb_if.write_en            = 1'b0;
        rb_if.read_en             = 1'b0;
        rb_if.in_rx_selector      = '0;
        rb_if.in_ry_selector      = '0;
        rb_if.in_indirect_mode_en = 1'b0;
        rb_if.in_data             = '0;

        // Reset pulse; bus drives zeros while held in reset with read_en=1.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rb_if.read_en = 1'b1;
        expect_out(KIND_BUS, 8'h00, "bus_in_reset");
        expect_out(KIND_RY,  8'h00, "ry_in_reset");
        rb_if.read_en = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            rb_if.in_rx_selector = 3'(i);
            expect_out(KIND_RX, 8'h00, $sformatf("reset_rx%0d", i));
        end
        expect_out(KIND_BUS, 8'hFF, "bus_released_after_reset");

        // Direct write with read overlap: old value before the edge, new after.
        @(negedge clk);
        rb_if.write_en       = 1'b1;
        rb_if.in_rx_selector = 3'd4;
        rb_if.in_data        = 8'hAA;
        expect_out(KIND_RX, 8'h00, "r4_before_edge");
        @(posedge clk);
        #1;
        rb_if.write_en = 1'b0;
        expect_out(KIND_RX, 8'hAA, "r4_after_write");

        do_write(3'd0, 8'hFF);
        expect_out(KIND_RX, 8'hFF, "r0_after_write");
        rb_if.in_ry_selector = 3'd0;
        expect_out(KIND_RY, 8'hFF, "ry0_read");

        // Released bus while addressing R4 (AA) must not show register data.
        rb_if.read_en        = 1'b0;
        rb_if.in_ry_selector = 3'd4;
        expect_out(KIND_BUS, 8'hFF, "bus_released_ry4");

        // Direct bus read.
        do_write(3'd3, 8'h01);
        rb_if.read_en        = 1'b1;
        rb_if.in_ry_selector = 3'd3;
        expect_out(KIND_BUS, 8'h01, "bus_direct_r3");

        // Indirect bus read.
        do_write(3'd0, 8'h04);
        do_write(3'd4, 8'h08);
        rb_if.in_ry_selector      = 3'd0;
        rb_if.in_indirect_mode_en = 1'b0;
        expect_out(KIND_BUS, 8'h04, "bus_direct_r0");
        rb_if.in_indirect_mode_en = 1'b1;
        expect_out(KIND_BUS, 8'h08, "bus_indirect_r0");
        expect_out(KIND_RY,  8'h04, "ry_unaffected_by_indirect");

        // Pointer upper bits ignored: R5=F9 points at R1.
        do_write(3'd1, 8'h3C);
        do_write(3'd5, 8'hF9);
        rb_if.in_ry_selector = 3'd5;
        expect_out(KIND_BUS, 8'h3C, "bus_indirect_masked");

        // Self-pointer: R6=E6 points at itself.
        do_write(3'd6, 8'hE6);
        rb_if.in_ry_selector = 3'd6;
        expect_out(KIND_BUS, 8'hE6, "bus_indirect_self");

        // write_en=0 leaves registers untouched.
        @(negedge clk);
        rb_if.write_en       = 1'b0;
        rb_if.in_rx_selector = 3'd2;
        rb_if.in_data        = 8'h77;
        @(posedge clk);
        expect_out(KIND_RX, 8'h00, "no_write_r2");

        // Asynchronous reset between edges while a write is pending.
        @(negedge clk);
        rb_if.write_en       = 1'b1;
        rb_if.in_rx_selector = 3'd4;
        rb_if.in_data        = 8'h55;
        rb_if.in_ry_selector = 3'd5;
        #2;
        rst_n = 1'b0;
        expect_out(KIND_RX,  8'h00, "async_rst_rx4");
        expect_out(KIND_RY,  8'h00, "async_rst_ry5");
        expect_out(KIND_BUS, 8'h00, "async_rst_bus");
        @(posedge clk);
        expect_out(KIND_RX,  8'h00, "rst_blocks_write");
        @(negedge clk);
        rb_if.write_en = 1'b0;
        rst_n = 1'b1;
        expect_out(KIND_RX, 8'h00, "r4_after_rst_release");

        // Drain the scoreboard with a bounded wait.
        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 100) begin
            -> mon_ev;
            #1;
            wait_cnt++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register_bank
